// File: rtl/regfile_hilo.sv
// GPR file and HI/LO pair fed by the writeback bus.
// Every read port bypasses the write retiring in the current cycle.
module regfile_hilo #(
    parameter  int REG_NUM = 32,
    parameter  int DATA_W  = 32,
    localparam int AW      = $clog2(REG_NUM),
    localparam int BUS_W   = 3 * DATA_W + AW + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  wb_to_rf_bus,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic              hi_we;
    logic              lo_we;
    logic              rf_we;
    logic [DATA_W-1:0] hi_wdata;
    logic [DATA_W-1:0] lo_wdata;
    logic [DATA_W-1:0] rf_wdata;
    logic [AW-1:0]     rf_waddr;

    assign {hi_we, lo_we, hi_wdata, lo_wdata,
            rf_we, rf_waddr, rf_wdata} = wb_to_rf_bus;

    logic [DATA_W-1:0] rf_q [REG_NUM];
    logic [DATA_W-1:0] rf_d [REG_NUM];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] lo_d;

    // Next-state values double as the bypassed HI/LO view.
    always_comb begin
        rf_d = rf_q;
        hi_d = hi_we ? hi_wdata : hi_q;
        lo_d = lo_we ? lo_wdata : lo_q;
        if (rf_we && (rf_waddr != '0)) begin
            rf_d[rf_waddr] = rf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            rf_q <= rf_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        hi_o   = '0;
        lo_o   = '0;
        if (rst) begin
            hi_o = hi_d;
            lo_o = lo_d;
            if (raddr1 != '0) begin
                rdata1 = (rf_we && (rf_waddr == raddr1)) ? rf_wdata
                                                         : rf_q[raddr1];
            end
            if (raddr2 != '0) begin
                rdata2 = (rf_we && (rf_waddr == raddr2)) ? rf_wdata
                                                         : rf_q[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo: reset, write/read, bypass,
// r0, HI/LO and asynchronous reset in mid-run.
module tb_regfile_hilo;

    logic         clk = 1'b0;
    logic         rst;
    logic [103:0] bus;
    logic [4:0]   raddr1;
    logic [4:0]   raddr2;
    logic [31:0]  rdata1;
    logic [31:0]  rdata2;
    logic [31:0]  hi_o;
    logic [31:0]  lo_o;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_hilo dut (
        .clk          (clk),
        .rst          (rst),
        .wb_to_rf_bus (bus),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    function automatic logic [103:0] mk(
        input logic        hwe,
        input logic        lwe,
        input logic [31:0] hwd,
        input logic [31:0] lwd,
        input logic        rwe,
        input logic [4:0]  wa,
        input logic [31:0] wd
    );
        return {hwe, lwe, hwd, lwd, rwe, wa, wd};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        bus    = mk(1'b1, 1'b1, 32'hAAAA, 32'h5555, 1'b1, 5'd5, 32'h1234);
        raddr1 = 5'd5;
        raddr2 = 5'd5;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_rdata1 got %h want %h", rdata1, 32'h0);
        end
        n_cmp++;
        if (hi_o !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_hi got %h want %h", hi_o, 32'h0);
        end
        n_cmp++;
        if (lo_o !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_lo got %h want %h", lo_o, 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus = '0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_bad++;
            $display("FAIL rel_rdata1 got %h want %h", rdata1, 32'h0);
        end
        n_cmp++;
        if ({hi_o, lo_o} !== 64'h0) begin
            n_bad++;
            $display("FAIL rel_hilo got %h want %h", {hi_o, lo_o}, 64'h0);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF);
        @(negedge clk);
        bus    = '0;
        raddr1 = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (rdata1 !== 32'hDEADBEEF) begin
                n_bad++;
                $display("FAIL wr_r3 cyc%0d got %h want %h",
                         i, rdata1, 32'hDEADBEEF);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bypass();
        bus = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h11);
        @(negedge clk);
        bus    = '0;
        raddr1 = 5'd7;
        raddr2 = 5'd7;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h11) begin
            n_bad++;
            $display("FAIL byp_pre got %h want %h", rdata1, 32'h11);
        end
        @(negedge clk);
        bus = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h22);
        #1;
        n_cmp++;
        if (rdata1 !== 32'h22) begin
            n_bad++;
            $display("FAIL byp_p1 got %h want %h", rdata1, 32'h22);
        end
        n_cmp++;
        if (rdata2 !== 32'h22) begin
            n_bad++;
            $display("FAIL byp_p2 got %h want %h", rdata2, 32'h22);
        end
        @(negedge clk);
        bus = '0;
        #1;
        n_cmp++;
        if ({rdata1, rdata2} !== {32'h22, 32'h22}) begin
            n_bad++;
            $display("FAIL byp_post got %h want %h",
                     {rdata1, rdata2}, {32'h22, 32'h22});
        end
    endtask

    task automatic test_r0();
        @(negedge clk);
        bus    = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #1;
        n_cmp++;
        if ({rdata1, rdata2} !== 64'h0) begin
            n_bad++;
            $display("FAIL r0_pre got %h want %h", {rdata1, rdata2}, 64'h0);
        end
        @(negedge clk);
        bus = '0;
        #1;
        n_cmp++;
        if ({rdata1, rdata2} !== 64'h0) begin
            n_bad++;
            $display("FAIL r0_post got %h want %h", {rdata1, rdata2}, 64'h0);
        end
    endtask

    task automatic test_hilo();
        @(negedge clk);
        bus = mk(1'b0, 1'b1, 32'h0, 32'h0BAD, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        bus = mk(1'b1, 1'b0, 32'hAAAA0000, 32'h5555, 1'b0, 5'd0, 32'h0);
        #1;
        n_cmp++;
        if (hi_o !== 32'hAAAA0000) begin
            n_bad++;
            $display("FAIL hi_byp got %h want %h", hi_o, 32'hAAAA0000);
        end
        n_cmp++;
        if (lo_o !== 32'h0BAD) begin
            n_bad++;
            $display("FAIL lo_hold got %h want %h", lo_o, 32'h0BAD);
        end
        @(negedge clk);
        bus = '0;
        #1;
        n_cmp++;
        if ({hi_o, lo_o} !== {32'hAAAA0000, 32'h0BAD}) begin
            n_bad++;
            $display("FAIL hilo_post got %h want %h",
                     {hi_o, lo_o}, {32'hAAAA0000, 32'h0BAD});
        end
        @(negedge clk);
        bus    = mk(1'b0, 1'b1, 32'h0, 32'h5555, 1'b1, 5'd9, 32'h99);
        raddr1 = 5'd9;
        #1;
        n_cmp++;
        if ({rdata1, hi_o, lo_o} !== {32'h99, 32'hAAAA0000, 32'h5555}) begin
            n_bad++;
            $display("FAIL combo_byp got %h want %h",
                     {rdata1, hi_o, lo_o}, {32'h99, 32'hAAAA0000, 32'h5555});
        end
        @(negedge clk);
        bus = '0;
        #1;
        n_cmp++;
        if ({rdata1, hi_o, lo_o} !== {32'h99, 32'hAAAA0000, 32'h5555}) begin
            n_bad++;
            $display("FAIL combo_post got %h want %h",
                     {rdata1, hi_o, lo_o}, {32'h99, 32'hAAAA0000, 32'h5555});
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        raddr1 = 5'd3;
        raddr2 = 5'd7;
        #1;
        n_cmp++;
        if ({rdata1, rdata2} !== {32'hDEADBEEF, 32'h22}) begin
            n_bad++;
            $display("FAIL ar_pre got %h want %h",
                     {rdata1, rdata2}, {32'hDEADBEEF, 32'h22});
        end
        bus = mk(1'b1, 1'b1, 32'h1, 32'h2, 1'b1, 5'd10, 32'hABC);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({rdata1, rdata2, hi_o, lo_o} !== 128'h0) begin
            n_bad++;
            $display("FAIL ar_clear got %h want %h",
                     {rdata1, rdata2, hi_o, lo_o}, 128'h0);
        end
        @(negedge clk);
        rst    = 1'b1;
        bus    = '0;
        raddr1 = 5'd10;
        raddr2 = 5'd9;
        #1;
        n_cmp++;
        if ({rdata1, rdata2, hi_o, lo_o} !== 128'h0) begin
            n_bad++;
            $display("FAIL ar_lost got %h want %h",
                     {rdata1, rdata2, hi_o, lo_o}, 128'h0);
        end
        @(negedge clk);
        bus = mk(1'b1, 1'b0, 32'hC0DE, 32'h0, 1'b1, 5'd10, 32'h77);
        @(negedge clk);
        bus = '0;
        #1;
        n_cmp++;
        if ({rdata1, hi_o, lo_o} !== {32'h77, 32'hC0DE, 32'h0}) begin
            n_bad++;
            $display("FAIL ar_resume got %h want %h",
                     {rdata1, hi_o, lo_o}, {32'h77, 32'hC0DE, 32'h0});
        end
    endtask

    initial begin
        rst    = 1'b0;
        bus    = '0;
        raddr1 = '0;
        raddr2 = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_hilo();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
